// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer for an async-read ROM feeding a 2-entry prefetch FIFO,
// with redirect flush, halt and sticky out-of-range/misaligned fault handling.
module instr_fetch_ctrl #(
    parameter int PC_WIDTH = 16,
    parameter int INSTR_WIDTH = 16,
    parameter int MEM_SIZE = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   halt_req,
    output logic                   ir_valid,
    output logic [INSTR_WIDTH-1:0] ir_data,
    output logic [PC_WIDTH-1:0]    ir_pc,
    input  logic                   ir_ready,
    output logic                   fetch_fault,
    output logic [1:0]             state
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT, FAULT} state_t;
    localparam logic [PC_WIDTH-2:0] MEM_WORDS = (PC_WIDTH-1)'(MEM_SIZE);
    state_t st;
    logic [PC_WIDTH-1:0] pc, pc1;
    logic [INSTR_WIDTH-1:0] d1;
    logic [1:0] count;
    logic pop, flush, fault, push;
    assign imem_addr = pc;
    assign state = st;
    assign ir_valid = count != 2'd0;
    assign pop = ir_valid & ir_ready;
    assign flush = redirect_valid & (st == FETCH || st == HALT);
    assign fault = pc[0] | (pc[PC_WIDTH-1:1] >= MEM_WORDS);
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign push = st == FETCH && !redirect_valid && !halt_req && !fault && (count != 2'd2 || pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            pc <= RESET_PC;
            count <= '0;
            ir_data <= '0;
            ir_pc <= '0;
            d1 <= '0;
            pc1 <= '0;
            fetch_fault <= 1'b0;
        end else begin
            case (st)
                IDLE: st <= halt_req ? HALT : FETCH;
                FETCH: begin
                    if (redirect_valid) begin
                        st <= halt_req ? HALT : FETCH;
                        pc <= redirect_pc;
                    end else if (halt_req) begin
                        st <= HALT;
                    end else if (fault) begin
                        st <= FAULT;
                        fetch_fault <= 1'b1;
                    end else if (push) begin
                        pc <= pc + PC_WIDTH'(2);
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        st <= FETCH;
                        pc <= redirect_pc;
                    end
                end
                default: ;
            endcase
            if (flush) begin
                count <= '0;
            end else begin
                count <= count + {1'b0, push} - {1'b0, pop};
                if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                    ir_data <= imem_rdata;
                    ir_pc <= pc;
                end else if (pop && count == 2'd2) begin
                    ir_data <= d1;
                    ir_pc <= pc1;
                end
                if (push && (count == 2'd2 || (count == 2'd1 && !pop))) begin
                    d1 <= imem_rdata;
                    pc1 <= pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed checks of fetch sequencing, backpressure, redirect, halt and faults.
module tb_instr_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, ir_data, ir_pc;
    logic redirect_valid, halt_req, ir_valid, ir_ready, fetch_fault;
    logic [1:0] state;
    int passed = 0;
    int total = 0;
    instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .fetch_fault(fetch_fault), .state(state)
    );
    always #5 clk = ~clk;
    assign imem_rdata = (imem_addr[15:1] < 15'd15) ? 16'hA000 + {1'b0, imem_addr[15:1]} : 16'hDEAD;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset(input logic ready);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        ir_ready = ready;
        tick();
        tick();
        rst = 1'b0;
    endtask
    initial begin
        do_reset(1'b1);
        chk("rst_valid", ir_valid, 0);
        chk("rst_state", state, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_data", ir_data, 0);
        chk("rst_pc", ir_pc, 0);
        chk("rst_addr", imem_addr, 0);
        tick();
        chk("e0_state", state, 1);
        chk("e0_valid", ir_valid, 0);
        tick();
        chk("e1_valid", ir_valid, 1);
        chk("e1_pc", ir_pc, 16'h0000);
        chk("e1_data", ir_data, 16'hA000);
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("stream_pc", ir_pc, 32'(2 * k));
            chk("stream_data", ir_data, 32'(16'hA000 + k));
        end
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) tick();
        chk("bp_valid", ir_valid, 1);
        chk("bp_addr", imem_addr, 16'h0004);
        chk("bp_data", ir_data, 16'hA000);
        ir_ready = 1'b1;
        tick();
        chk("bp_drain1", ir_data, 16'hA001);
        tick();
        chk("bp_drain2", ir_data, 16'hA002);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        chk("redir_bubble", ir_valid, 0);
        tick();
        chk("redir_valid", ir_valid, 1);
        chk("redir_pc", ir_pc, 16'h0010);
        chk("redir_data", ir_data, 16'hA008);
        redirect_valid = 1'b1;
        redirect_pc = 16'h001C;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("last_data", ir_data, 16'hA00E);
        chk("last_pc", ir_pc, 16'h001C);
        chk("last_fault", fetch_fault, 0);
        tick();
        chk("oor_state", state, 3);
        chk("oor_fault", fetch_fault, 1);
        chk("oor_valid", ir_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        chk("fault_hold_state", state, 3);
        chk("fault_hold_addr", imem_addr, 16'h001E);
        chk("fault_hold_valid", ir_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fault_clr_state", state, 0);
        chk("fault_clr_flag", fetch_fault, 0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0003;
        tick();
        redirect_valid = 1'b0;
        chk("mis_bubble", ir_valid, 0);
        tick();
        chk("mis_state", state, 3);
        chk("mis_fault", fetch_fault, 1);
        chk("mis_valid", ir_valid, 0);
        chk("mis_addr", imem_addr, 16'h0003);
        do_reset(1'b0);
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_state", state, 2);
        chk("halt_data", ir_data, 16'hA000);
        ir_ready = 1'b1;
        tick();
        chk("halt_drain", ir_data, 16'hA001);
        chk("halt_drain_state", state, 2);
        tick();
        chk("halt_empty", ir_valid, 0);
        tick();
        chk("halt_nopush", ir_valid, 0);
        chk("halt_addr", imem_addr, 16'h0004);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        chk("resume_state", state, 1);
        tick();
        chk("resume_data", ir_data, 16'hA000);
        chk("resume_pc", ir_pc, 16'h0000);
        tick();
        chk("resume_next", ir_data, 16'hA001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", ir_valid, 0);
        chk("midrst_state", state, 0);
        chk("midrst_addr", imem_addr, 16'h0000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
